// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush and optional skid entry.
// Data payload survives bubbles; control payload reads as zero whenever the stage is empty.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o
);

  localparam bit HasSkid = (SKID != 0);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [1:0]        occ_q;
  logic              in_fire;
  logic              out_fire;

  assign out_valid_o = (state_q != StEmpty);
  assign out_data_o  = main_data_q;
  assign out_ctrl_o  = main_ctrl_q;
  assign occupancy_o = occ_q;

  // With a skid entry, ready is a pure function of state so it never sees out_ready_i.
  generate
    if (HasSkid) begin : g_ready_skid
      assign in_ready_o = (state_q != StTwo);
    end else begin : g_ready_single
      assign in_ready_o = ~out_valid_o | out_ready_i;
    end
  endgenerate

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StEmpty;
      occ_q       <= 2'd0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush_i) begin
      // Any accepted input this cycle is dropped; an out_fire was already consumed downstream.
      state_q     <= StEmpty;
      occ_q       <= 2'd0;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_data_q <= in_data_i;
            main_ctrl_q <= in_ctrl_i;
            state_q     <= StOne;
            occ_q       <= 2'd1;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_data_q <= in_data_i;
            main_ctrl_q <= in_ctrl_i;
          end else if (in_fire && HasSkid) begin
            skid_data_q <= in_data_i;
            skid_ctrl_q <= in_ctrl_i;
            state_q     <= StTwo;
            occ_q       <= 2'd2;
          end else if (out_fire) begin
            main_ctrl_q <= '0;
            state_q     <= StEmpty;
            occ_q       <= 2'd0;
          end
        end
        StTwo: begin
          if (out_fire) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
            skid_ctrl_q <= '0;
            state_q     <= StOne;
            occ_q       <= 2'd1;
          end
        end
        default: begin
          main_ctrl_q <= '0;
          skid_ctrl_q <= '0;
          state_q     <= StEmpty;
          occ_q       <= 2'd0;
        end
      endcase
    end
  end

  a_occ_matches_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    ((occ_q == 2'd0) == !out_valid_o));

  a_ctrl_zero_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o || (main_ctrl_q == '0)));

  a_single_never_two: assert property (@(posedge clk_i) disable iff (rst_i)
    (HasSkid || (occ_q != 2'd2)));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table on SKID=1/SKID=0 instances, async reset check,
// and a randomised run of both modes against a two-entry reference model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv1 = 1'b0, rdy1 = 1'b1, fl1 = 1'b0;
  logic [31:0] d1 = '0;
  logic [7:0]  c1 = '0;
  logic        ov1, ir1;
  logic [31:0] od1;
  logic [7:0]  oc1;
  logic [1:0]  occ1;

  logic        iv0 = 1'b0, rdy0 = 1'b1, fl0 = 1'b0;
  logic [31:0] d0 = '0;
  logic [7:0]  c0 = '0;
  logic        ov0, ir0;
  logic [31:0] od0;
  logic [7:0]  oc0;
  logic [1:0]  occ0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1)) u_dut_skid (
    .clk_i(clk), .rst_i(rst), .flush_i(fl1),
    .in_valid_i(iv1), .in_ready_o(ir1), .in_data_i(d1), .in_ctrl_i(c1),
    .out_valid_o(ov1), .out_ready_i(rdy1), .out_data_o(od1), .out_ctrl_o(oc1),
    .occupancy_o(occ1)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) u_dut_single (
    .clk_i(clk), .rst_i(rst), .flush_i(fl0),
    .in_valid_i(iv0), .in_ready_o(ir0), .in_data_i(d0), .in_ctrl_i(c0),
    .out_valid_o(ov0), .out_ready_i(rdy0), .out_data_o(od0), .out_ctrl_o(oc0),
    .occupancy_o(occ0)
  );

  typedef struct {
    bit          s;
    bit          iv;
    logic [31:0] d;
    logic [7:0]  c;
    bit          rdy;
    bit          fl;
    bit          ev;
    logic [31:0] ed;
    logic [7:0]  ec;
    logic [1:0]  eo;
    bit          er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int s, int iv, int d, int c, int rdy, int fl,
                              int ev, int ed, int ec, int eo, int er);
    vec_t v;
    v.s = (s != 0);   v.iv = (iv != 0); v.d = d;       v.c = c[7:0];
    v.rdy = (rdy != 0); v.fl = (fl != 0); v.ev = (ev != 0); v.ed = ed;
    v.ec = ec[7:0];   v.eo = eo[1:0];   v.er = (er != 0);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    iv1 = 1'b0; rdy1 = 1'b1; fl1 = 1'b0; d1 = '0; c1 = '0;
    iv0 = 1'b0; rdy0 = 1'b1; fl0 = 1'b0; d0 = '0; c0 = '0;
  endtask

  // Inputs go in after the falling edge; outputs checked 1ns later, before the next rising edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    idle_all();
    if (v.s) begin
      iv1 = v.iv; d1 = v.d; c1 = v.c; rdy1 = v.rdy; fl1 = v.fl;
    end else begin
      iv0 = v.iv; d0 = v.d; c0 = v.c; rdy0 = v.rdy; fl0 = v.fl;
    end
    #1;
    if (v.s) begin
      check($sformatf("v%0d skid valid", idx), 32'(ov1), 32'(v.ev));
      check($sformatf("v%0d skid data", idx), od1, v.ed);
      check($sformatf("v%0d skid ctrl", idx), 32'(oc1), 32'(v.ec));
      check($sformatf("v%0d skid occ", idx), 32'(occ1), 32'(v.eo));
      check($sformatf("v%0d skid in_ready", idx), 32'(ir1), 32'(v.er));
    end else begin
      check($sformatf("v%0d single valid", idx), 32'(ov0), 32'(v.ev));
      check($sformatf("v%0d single data", idx), od0, v.ed);
      check($sformatf("v%0d single ctrl", idx), 32'(oc0), 32'(v.ec));
      check($sformatf("v%0d single occ", idx), 32'(occ0), 32'(v.eo));
      check($sformatf("v%0d single in_ready", idx), 32'(ir0), 32'(v.er));
    end
  endtask

  // Two-entry reference: n items, h = head, t = second; each entry is {data, ctrl}.
  task automatic model_cycle(input bit s, input int cyc,
                             input bit iv, input bit rdy, input bit fl,
                             input logic [31:0] d, input logic [7:0] c,
                             input bit ov, input bit ir, input logic [31:0] od,
                             input logic [7:0] oc, input logic [1:0] occ,
                             inout int n, inout logic [39:0] h, inout logic [39:0] t);
    bit exp_ready;
    bit ifire;
    bit ofire;
    string tag;
    tag = s ? "skid" : "single";
    exp_ready = s ? (n < 2) : ((n == 0) || rdy);
    check($sformatf("rnd%0d %s valid", cyc, tag), 32'(ov), 32'(n > 0));
    check($sformatf("rnd%0d %s occ", cyc, tag), 32'(occ), n);
    check($sformatf("rnd%0d %s in_ready", cyc, tag), 32'(ir), 32'(exp_ready));
    if (n > 0) begin
      check($sformatf("rnd%0d %s data", cyc, tag), od, h[39:8]);
      check($sformatf("rnd%0d %s ctrl", cyc, tag), 32'(oc), 32'(h[7:0]));
    end else begin
      check($sformatf("rnd%0d %s ctrl empty", cyc, tag), 32'(oc), 32'd0);
    end
    ifire = iv && exp_ready;
    ofire = (n > 0) && rdy;
    if (fl) begin
      n = 0;
    end else begin
      if (ofire) begin
        h = t;
        n--;
      end
      if (ifire) begin
        if (n == 0) h = {d, c};
        else        t = {d, c};
        n++;
      end
    end
  endtask

  initial begin
    int n1 = 0;
    int n0 = 0;
    logic [39:0] h1 = '0, t1 = '0, h0 = '0, t0 = '0;

    // SKID=1: back-to-back stream, stall with skid fill, flush at occupancy 2, flush in ONE.
    vecs.push_back(mk(1, 1, 'h11, 'h81, 1, 0,  0, 'h00, 'h00, 0, 1));
    vecs.push_back(mk(1, 1, 'h22, 'h82, 1, 0,  1, 'h11, 'h81, 1, 1));
    vecs.push_back(mk(1, 1, 'h33, 'h83, 1, 0,  1, 'h22, 'h82, 1, 1));
    vecs.push_back(mk(1, 0, 'h00, 'h00, 1, 0,  1, 'h33, 'h83, 1, 1));
    vecs.push_back(mk(1, 0, 'h00, 'h00, 1, 0,  0, 'h33, 'h00, 0, 1));
    vecs.push_back(mk(1, 1, 'hA0, 'h10, 1, 0,  0, 'h33, 'h00, 0, 1));
    vecs.push_back(mk(1, 1, 'hA1, 'h11, 0, 0,  1, 'hA0, 'h10, 1, 1));
    vecs.push_back(mk(1, 1, 'hA2, 'h12, 0, 0,  1, 'hA0, 'h10, 2, 0));
    vecs.push_back(mk(1, 1, 'hA2, 'h12, 0, 0,  1, 'hA0, 'h10, 2, 0));
    vecs.push_back(mk(1, 1, 'hA2, 'h12, 1, 0,  1, 'hA0, 'h10, 2, 0));
    vecs.push_back(mk(1, 1, 'hA2, 'h12, 1, 0,  1, 'hA1, 'h11, 1, 1));
    vecs.push_back(mk(1, 0, 'h00, 'h00, 1, 0,  1, 'hA2, 'h12, 1, 1));
    vecs.push_back(mk(1, 0, 'h00, 'h00, 1, 0,  0, 'hA2, 'h00, 0, 1));
    vecs.push_back(mk(1, 1, 'hB0, 'h20, 0, 0,  0, 'hA2, 'h00, 0, 1));
    vecs.push_back(mk(1, 1, 'hB1, 'h21, 0, 0,  1, 'hB0, 'h20, 1, 1));
    vecs.push_back(mk(1, 1, 'h55, 'h55, 0, 1,  1, 'hB0, 'h20, 2, 0));
    vecs.push_back(mk(1, 0, 'h00, 'h00, 1, 0,  0, 'hB0, 'h00, 0, 1));
    vecs.push_back(mk(1, 1, 'hC0, 'h30, 1, 0,  0, 'hB0, 'h00, 0, 1));
    vecs.push_back(mk(1, 0, 'h00, 'h00, 1, 0,  1, 'hC0, 'h30, 1, 1));
    vecs.push_back(mk(1, 0, 'h00, 'h00, 1, 0,  0, 'hC0, 'h00, 0, 1));
    vecs.push_back(mk(1, 1, 'hD0, 'h40, 1, 0,  0, 'hC0, 'h00, 0, 1));
    vecs.push_back(mk(1, 1, 'hD1, 'h41, 1, 1,  1, 'hD0, 'h40, 1, 1));
    vecs.push_back(mk(1, 0, 'h00, 'h00, 1, 0,  0, 'hD0, 'h00, 0, 1));
    // SKID=0: same-cycle ready drop on stall, pass-through on release, flush.
    vecs.push_back(mk(0, 1, 'hE0, 'h50, 1, 0,  0, 'h00, 'h00, 0, 1));
    vecs.push_back(mk(0, 1, 'hE1, 'h51, 0, 0,  1, 'hE0, 'h50, 1, 0));
    vecs.push_back(mk(0, 1, 'hE1, 'h51, 0, 0,  1, 'hE0, 'h50, 1, 0));
    vecs.push_back(mk(0, 1, 'hE1, 'h51, 1, 0,  1, 'hE0, 'h50, 1, 1));
    vecs.push_back(mk(0, 0, 'h00, 'h00, 1, 0,  1, 'hE1, 'h51, 1, 1));
    vecs.push_back(mk(0, 0, 'h00, 'h00, 0, 0,  0, 'hE1, 'h00, 0, 1));
    vecs.push_back(mk(0, 1, 'hF0, 'h60, 0, 0,  0, 'hE1, 'h00, 0, 1));
    vecs.push_back(mk(0, 1, 'hF1, 'h61, 0, 1,  1, 'hF0, 'h60, 1, 0));
    vecs.push_back(mk(0, 0, 'h00, 'h00, 1, 0,  0, 'hF0, 'h00, 0, 1));

    idle_all();
    #12 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Fill the skid stage to occupancy 2, then assert reset between clock edges.
    @(negedge clk);
    idle_all();
    iv1 = 1'b1; d1 = 32'h77; c1 = 8'h71; rdy1 = 1'b0;
    @(negedge clk);
    d1 = 32'h78; c1 = 8'h72;
    @(negedge clk);
    iv1 = 1'b0;
    #1;
    check("pre-reset occ", 32'(occ1), 32'd2);
    check("pre-reset data", od1, 32'h77);
    #1 rst = 1'b1;
    #1;
    check("async rst valid", 32'(ov1), 32'd0);
    check("async rst data", od1, 32'd0);
    check("async rst ctrl", 32'(oc1), 32'd0);
    check("async rst occ", 32'(occ1), 32'd0);
    check("async rst in_ready", 32'(ir1), 32'd1);
    check("async rst single data", od0, 32'd0);
    #1 rst = 1'b0;
    rdy1 = 1'b1;
    @(negedge clk);
    #1;
    check("post-reset skid item gone", 32'(ov1), 32'd0);

    // Random valid/ready/flush in both modes against the reference model.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      iv1  = ($urandom_range(0, 9) < 7);
      rdy1 = ($urandom_range(0, 9) < 6);
      fl1  = ($urandom_range(0, 31) == 0);
      d1   = $urandom;
      c1   = 8'($urandom);
      iv0  = ($urandom_range(0, 9) < 7);
      rdy0 = ($urandom_range(0, 9) < 6);
      fl0  = ($urandom_range(0, 31) == 0);
      d0   = $urandom;
      c0   = 8'($urandom);
      #1;
      model_cycle(1'b1, cyc, iv1, rdy1, fl1, d1, c1, ov1, ir1, od1, oc1, occ1, n1, h1, t1);
      model_cycle(1'b0, cyc, iv0, rdy0, fl0, d0, c0, ov0, ir0, od0, oc0, occ0, n0, h0, t0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, flush (bubble insertion) and an optional skid buffer. It is the generic replacement for the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the miniRV pipeline. Stalls come from downstream back-pressure, and flushes come from hazard/branch logic. Payload is split into a data field, which is held through bubbles, and a control field, which is forced to zero whenever the stage holds no valid instruction.

## Interface
- DATA_W, 32: width of data payload (PC, ALU result, rD2, ...); never cleared except by reset.
- CTRL_W, 8: width of control payload (rf_we, ram_we, rf_wsel, wR, ...); zero whenever the stage is empty.
- SKID, 1: 0 = single-entry stage, combinational ready; 1 = two-entry skid stage, in_ready_o decoded from state only.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous flush; empties the stage.
- in_valid_i  in  1  upstream item valid.
- in_ready_o  out  1  stage can accept an item.
- in_data_i  in  DATA_W  upstream data payload.
- in_ctrl_i  in  CTRL_W  upstream control payload.
- out_valid_o  out  1  stage presents a valid item.
- out_ready_i  in  1  downstream accepts; 0 = stall.
- out_data_o  out  DATA_W  head data payload (registered).
- out_ctrl_o  out  CTRL_W  head control payload (registered).
- occupancy_o  out  2  number of items held, 0..2.

## Operation
- in_fire = in_valid_i & in_ready_o.
- out_fire = out_valid_o & out_ready_i.
- Storage: main register (drives outputs) and, when SKID=1, a skid register. FIFO order is always preserved.
- States: EMPTY (occ 0), ONE (main full, occ 1), TWO (main and skid full, occ 2; SKID=1 only).
- out_valid_o = (state != EMPTY).
- SKID=0: in_ready_o = ~out_valid_o | out_ready_i.
- SKID=1: in_ready_o = (state != TWO). It has no combinational path from out_ready_i.
- EMPTY: in_fire -> load main, go to ONE.
- ONE:
  - in_fire & out_fire -> load main from input, stay in ONE.
  - in_fire & ~out_fire -> load skid (SKID=1), go to TWO. This case cannot occur when SKID=0.
  - ~in_fire & out_fire -> go to EMPTY.
  - Otherwise hold.
- TWO: out_fire -> main <= skid, go to ONE; otherwise hold. Input is never accepted in TWO.
- Any transition into EMPTY writes main ctrl to 0. Data registers keep their last value.
- Flush (flush_i=1) has priority over everything:
  - Next state is EMPTY and main ctrl and skid ctrl are cleared.
  - Any in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed downstream.
- Reset: state EMPTY, every data/ctrl register 0, so out_valid_o=0, out_data_o=0, out_ctrl_o=0, occupancy_o=0. in_ready_o=1 in both modes.

## Timing
- Latency: an item accepted at edge N is on out_* after edge N (one cycle), in both modes.
- Throughput: one item per cycle when out_ready_i=1 continuously.
- No combinational path from in_* to out_*. When SKID=1, no combinational path from out_ready_i to in_ready_o.
- SKID=1 after a stall: the item accepted in the cycle where out_ready_i fell is held in skid. in_ready_o drops the following cycle.
- Flush takes effect at the next edge: out_valid_o=0 and out_ctrl_o=0 one cycle after flush_i is sampled high.
- Reset asserted mid-operation drops all held items immediately (asynchronously); no partial state survives.
- occupancy_o is registered and always consistent with out_valid_o (occ=0 if and only if out_valid_o=0).

## Test plan
- Reset, then idle: out_valid_o=0, out_ctrl_o=0, out_data_o=0, in_ready_o=1, occupancy_o=0.
- SKID=1, back-to-back 0x11,0x22,0x33 with ctrl 0x81,0x82,0x83 and out_ready_i=1 -> one cycle later outputs 0x11,0x22,0x33 on consecutive cycles, no bubbles.
- SKID=1 stall:
  - Stimulus: stream 0xA0,0xA1,0xA2, drop out_ready_i during the cycle 0xA1 is offered, hold low 3 cycles, then raise.
  - Required: occupancy_o reaches 2 and in_ready_o=0 while 0xA2 is held off; output order is 0xA0,0xA1,0xA2 with none lost or duplicated.
- SKID=0 stall: out_ready_i=0 with main full -> in_ready_o=0 in the same cycle; data held stable until release.
- Flush with occupancy 2 and in_valid_i=1 (data 0x55) -> next cycle out_valid_o=0, out_ctrl_o=0, occupancy_o=0; 0x55 never appears on the output.
- Random valid/ready/flush for 10k cycles in both SKID modes, checked against a reference queue model -> identical output sequence, and out_ctrl_o=0 whenever out_valid_o=0.
